// File: rtl/mem_arb_pkg.sv
// Shared types for mem_port_arbiter: arbiter FSM states, response owner, starvation counter width.
package mem_arb_pkg;

  typedef enum logic {ARB_IDLE, ARB_WAIT} arb_state_e;

  typedef enum logic [1:0] {OWN_NONE, OWN_IF, OWN_LSU} arb_owner_e;

  localparam int STARVE_W = 4;

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter with synchronous clear; clear wins over increment.
module sat_counter #(
  parameter int          W   = 4,
  parameter logic [W-1:0] MAX = '1
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         inc,
  input  logic         clr,
  output logic [W-1:0] cnt
);

  logic [W-1:0] cnt_q;
  logic [W-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = '0;
    end else if (inc && (cnt_q != MAX)) begin
      cnt_d = cnt_q + W'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt = cnt_q;

endmodule

// File: rtl/mem_port_arbiter.sv
// Arbitrates IF fetch and LSU data ports onto one single-ported memory, one transaction in flight.
// Optional wait-cycle performance counters are built when ARB_PERF_CNT_EN is defined.
module mem_port_arbiter
  import mem_arb_pkg::*;
#(
  parameter int ADDR_W     = 32,
  parameter int DATA_W     = 32,
  parameter int STARVE_MAX = 4
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                if_req,
  input  logic [ADDR_W-1:0]   if_addr,
  output logic                if_gnt,
  output logic                if_rvalid,
  output logic [DATA_W-1:0]   if_rdata,
  input  logic                lsu_req,
  input  logic                lsu_we,
  input  logic [DATA_W/8-1:0] lsu_be,
  input  logic [ADDR_W-1:0]   lsu_addr,
  input  logic [DATA_W-1:0]   lsu_wdata,
  output logic                lsu_gnt,
  output logic                lsu_rvalid,
  output logic [DATA_W-1:0]   lsu_rdata,
  output logic                mem_req,
  output logic                mem_we,
  output logic [DATA_W/8-1:0] mem_be,
  output logic [ADDR_W-1:0]   mem_addr,
  output logic [DATA_W-1:0]   mem_wdata,
  input  logic                mem_gnt,
  input  logic                mem_rvalid,
  input  logic [DATA_W-1:0]   mem_rdata,
  output logic                if_stall,
  output logic                ex_stall,
  output logic [31:0]         perf_if_wait,
  output logic [31:0]         perf_lsu_wait
);

  arb_state_e state_q, state_d;
  arb_owner_e owner_q, owner_d;
  arb_owner_e winner;
  logic       store_q, store_d;
  logic       arb_en;
  logic       rsp_valid;
  logic [STARVE_W-1:0] starve_cnt;

  // Arbitration is open when idle, and also on the response cycle so a new grant follows without a bubble.
  always_comb begin
    arb_en = (state_q == ARB_IDLE) || mem_rvalid;
    winner = OWN_NONE;
    if (!rst && arb_en) begin
      if (if_req && (!lsu_req || (starve_cnt == STARVE_W'(STARVE_MAX)))) begin
        winner = OWN_IF;
      end else if (lsu_req) begin
        winner = OWN_LSU;
      end
    end
  end

  always_comb begin
    mem_req   = 1'b0;
    mem_we    = 1'b0;
    mem_be    = '0;
    mem_addr  = '0;
    mem_wdata = '0;
    case (winner)
      OWN_IF: begin
        mem_req  = 1'b1;
        mem_be   = '1;
        mem_addr = if_addr;
      end
      OWN_LSU: begin
        mem_req   = 1'b1;
        mem_we    = lsu_we;
        mem_be    = lsu_be;
        mem_addr  = lsu_addr;
        mem_wdata = lsu_wdata;
      end
      default: ;
    endcase
  end

  assign if_gnt    = mem_gnt && (winner == OWN_IF);
  assign lsu_gnt   = mem_gnt && (winner == OWN_LSU);
  assign rsp_valid = mem_rvalid && (state_q == ARB_WAIT);

  assign if_rvalid  = rsp_valid && (owner_q == OWN_IF);
  assign lsu_rvalid = rsp_valid && (owner_q == OWN_LSU);
  assign if_rdata   = if_rvalid ? mem_rdata : '0;
  assign lsu_rdata  = (lsu_rvalid && !store_q) ? mem_rdata : '0;

  assign if_stall = !rst && if_req && !if_rvalid;
  assign ex_stall = !rst && lsu_req && !lsu_rvalid;

  always_comb begin
    state_d = state_q;
    owner_d = owner_q;
    store_d = store_q;
    if (if_gnt || lsu_gnt) begin
      state_d = ARB_WAIT;
      owner_d = winner;
      store_d = lsu_gnt && lsu_we;
    end else if (rsp_valid) begin
      state_d = ARB_IDLE;
      owner_d = OWN_NONE;
      store_d = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ARB_IDLE;
      owner_q <= OWN_NONE;
      store_q <= 1'b0;
    end else begin
      state_q <= state_d;
      owner_q <= owner_d;
      store_q <= store_d;
    end
  end

  sat_counter #(
    .W   (STARVE_W),
    .MAX (STARVE_W'(STARVE_MAX))
  ) u_starve (
    .clk (clk),
    .rst (rst),
    .inc (if_req && lsu_req && lsu_gnt),
    .clr (if_gnt),
    .cnt (starve_cnt)
  );

`ifdef ARB_PERF_CNT_EN
  sat_counter #(.W(32), .MAX(32'hFFFF_FFFF)) u_perf_if (
    .clk (clk),
    .rst (rst),
    .inc (if_stall),
    .clr (1'b0),
    .cnt (perf_if_wait)
  );

  sat_counter #(.W(32), .MAX(32'hFFFF_FFFF)) u_perf_lsu (
    .clk (clk),
    .rst (rst),
    .inc (ex_stall),
    .clr (1'b0),
    .cnt (perf_lsu_wait)
  );
`else
  assign perf_if_wait  = 32'd0;
  assign perf_lsu_wait = 32'd0;
`endif

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed self-checking bench for mem_port_arbiter with a one-cycle-latency memory model.
module tb_mem_port_arbiter;
  import mem_arb_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic        if_req;
  logic [31:0] if_addr;
  logic        if_gnt, if_rvalid;
  logic [31:0] if_rdata;
  logic        lsu_req, lsu_we;
  logic [3:0]  lsu_be;
  logic [31:0] lsu_addr, lsu_wdata;
  logic        lsu_gnt, lsu_rvalid;
  logic [31:0] lsu_rdata;
  logic        mem_req, mem_we;
  logic [3:0]  mem_be;
  logic [31:0] mem_addr, mem_wdata;
  logic        mem_gnt;
  logic        mem_rvalid;
  logic [31:0] mem_rdata;
  logic        if_stall, ex_stall;
  logic [31:0] perf_if_wait, perf_lsu_wait;

  logic        hold_resp, inject_rv;
  logic [31:0] inject_rd;
  logic        model_rv;
  logic [31:0] model_rd;
  logic [31:0] mem_arr [0:255];

  int n_run  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  mem_port_arbiter dut (
    .clk (clk), .rst (rst),
    .if_req (if_req), .if_addr (if_addr), .if_gnt (if_gnt),
    .if_rvalid (if_rvalid), .if_rdata (if_rdata),
    .lsu_req (lsu_req), .lsu_we (lsu_we), .lsu_be (lsu_be),
    .lsu_addr (lsu_addr), .lsu_wdata (lsu_wdata), .lsu_gnt (lsu_gnt),
    .lsu_rvalid (lsu_rvalid), .lsu_rdata (lsu_rdata),
    .mem_req (mem_req), .mem_we (mem_we), .mem_be (mem_be),
    .mem_addr (mem_addr), .mem_wdata (mem_wdata), .mem_gnt (mem_gnt),
    .mem_rvalid (mem_rvalid), .mem_rdata (mem_rdata),
    .if_stall (if_stall), .ex_stall (ex_stall),
    .perf_if_wait (perf_if_wait), .perf_lsu_wait (perf_lsu_wait)
  );

  // Memory model: words 0x000..0x1FC preload to 0xA000_0000|addr, the rest to 0; stores answer 0xBAD0_BAD0.
  always @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < 256; i++) mem_arr[i] <= (i < 128) ? (32'hA000_0000 | 32'(i << 2)) : 32'd0;
      model_rv <= 1'b0;
      model_rd <= 32'd0;
    end else begin
      model_rv <= 1'b0;
      if (mem_req && mem_gnt) begin
        model_rv <= !hold_resp;
        if (mem_we) begin
          for (int b = 0; b < 4; b++)
            if (mem_be[b]) mem_arr[mem_addr[9:2]][b*8 +: 8] <= mem_wdata[b*8 +: 8];
          model_rd <= 32'hBAD0_BAD0;
        end else begin
          model_rd <= mem_arr[mem_addr[9:2]];
        end
      end
    end
  end

  assign mem_rvalid = model_rv | inject_rv;
  assign mem_rdata  = inject_rv ? inject_rd : model_rd;

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  task automatic sample;
    @(negedge clk);
  endtask

  task automatic test_reset;
    rst = 1'b1; if_req = 1'b1; lsu_req = 1'b1;
    repeat (2) @(posedge clk);
    sample();
    n_run++; if ({mem_req, if_gnt, lsu_gnt, if_rvalid, lsu_rvalid} !== 5'b0) begin
      n_fail++; $display("FAIL rst_handshake got %b required 00000", {mem_req, if_gnt, lsu_gnt, if_rvalid, lsu_rvalid});
    end
    n_run++; if ({if_stall, ex_stall} !== 2'b00) begin
      n_fail++; $display("FAIL rst_stall got %b required 00", {if_stall, ex_stall});
    end
    n_run++; if ({perf_if_wait, perf_lsu_wait} !== 64'd0) begin
      n_fail++; $display("FAIL rst_perf got %h/%h required 0/0", perf_if_wait, perf_lsu_wait);
    end
    if_req = 1'b0; lsu_req = 1'b0;
    step();
    rst = 1'b0;
    sample();
    n_run++; if (dut.state_q !== ARB_IDLE || dut.owner_q !== OWN_NONE || dut.starve_cnt !== 4'd0) begin
      n_fail++; $display("FAIL rst_state got %0d/%0d/%0d required 0/0/0", dut.state_q, dut.owner_q, dut.starve_cnt);
    end
  endtask

  task automatic test_both_same_cycle;
    step();
    if_req = 1'b1; if_addr = 32'h10;
    lsu_req = 1'b1; lsu_we = 1'b0; lsu_be = 4'hF; lsu_addr = 32'h100;
    sample();
    n_run++; if ({lsu_gnt, if_gnt, ex_stall, if_stall} !== 4'b1011 || mem_addr !== 32'h100) begin
      n_fail++; $display("FAIL both_c0 got gnt/stall %b addr %h required 1011 100", {lsu_gnt, if_gnt, ex_stall, if_stall}, mem_addr);
    end
    step();
    lsu_req = 1'b0;
    sample();
    n_run++; if (lsu_rvalid !== 1'b1 || lsu_rdata !== 32'hA000_0100) begin
      n_fail++; $display("FAIL both_lsu_rsp got %b %h required 1 a0000100", lsu_rvalid, lsu_rdata);
    end
    n_run++; if ({if_gnt, ex_stall, if_stall} !== 3'b101 || mem_addr !== 32'h10) begin
      n_fail++; $display("FAIL both_c1 got %b addr %h required 101 10", {if_gnt, ex_stall, if_stall}, mem_addr);
    end
    step();
    if_req = 1'b0;
    sample();
    n_run++; if (if_rvalid !== 1'b1 || if_rdata !== 32'hA000_0010 || if_stall !== 1'b0) begin
      n_fail++; $display("FAIL both_if_rsp got %b %h stall %b required 1 a0000010 0", if_rvalid, if_rdata, if_stall);
    end
`ifdef ARB_PERF_CNT_EN
    n_run++; if (perf_if_wait !== 32'd2 || perf_lsu_wait !== 32'd1) begin
      n_fail++; $display("FAIL perf_cnt got if=%0d lsu=%0d required if=2 lsu=1", perf_if_wait, perf_lsu_wait);
    end
`else
    n_run++; if (perf_if_wait !== 32'd0 || perf_lsu_wait !== 32'd0) begin
      n_fail++; $display("FAIL perf_tied got if=%0d lsu=%0d required 0 0", perf_if_wait, perf_lsu_wait);
    end
`endif
  endtask

  task automatic test_if_back_to_back;
    logic [31:0] exp_rd [3];
    exp_rd[0] = 32'hA000_0000; exp_rd[1] = 32'hA000_0004; exp_rd[2] = 32'hA000_0008;
    for (int k = 0; k < 4; k++) begin
      step();
      if_req  = (k < 3);
      if_addr = 32'(k * 4);
      sample();
      n_run++; if (if_gnt !== (k < 3) || mem_req !== (k < 3) || lsu_gnt !== 1'b0 || lsu_rvalid !== 1'b0) begin
        n_fail++; $display("FAIL if_b2b_gnt%0d got gnt %b req %b lsu %b%b required %b %b 00", k, if_gnt, mem_req, lsu_gnt, lsu_rvalid, k < 3, k < 3);
      end
      if (k > 0) begin
        n_run++; if (if_rvalid !== 1'b1 || if_rdata !== exp_rd[k-1]) begin
          n_fail++; $display("FAIL if_b2b_data%0d got %b %h required 1 %h", k, if_rvalid, if_rdata, exp_rd[k-1]);
        end
      end
      if (k < 3) begin
        n_run++; if (mem_be !== 4'hF || mem_wdata !== 32'd0 || mem_we !== 1'b0) begin
          n_fail++; $display("FAIL if_b2b_fields%0d got be %h wd %h we %b required f 0 0", k, mem_be, mem_wdata, mem_we);
        end
      end
    end
    step();
    sample();
    n_run++; if (if_rvalid !== 1'b0 || dut.state_q !== ARB_IDLE) begin
      n_fail++; $display("FAIL if_b2b_idle got rvalid %b state %0d required 0 0", if_rvalid, dut.state_q);
    end
  endtask

  task automatic test_starvation;
    int  n_lsu  = 0;
    bit  got_if = 1'b0;
    step();
    if_req = 1'b1; if_addr = 32'h20;
    lsu_req = 1'b1; lsu_we = 1'b0; lsu_be = 4'hF; lsu_addr = 32'h110;
    for (int c = 0; c < 20 && !got_if; c++) begin
      sample();
      if (if_gnt) got_if = 1'b1;
      else if (lsu_gnt) n_lsu++;
      if (!got_if) step();
    end
    n_run++; if (got_if !== 1'b1 || n_lsu != 4) begin
      n_fail++; $display("FAIL starve_grants got if_gnt %b after %0d lsu grants required 1 after 4", got_if, n_lsu);
    end
    step();
    if_req = 1'b0; lsu_req = 1'b0;
    sample();
    n_run++; if (if_rvalid !== 1'b1 || if_rdata !== 32'hA000_0020 || dut.starve_cnt !== 4'd0) begin
      n_fail++; $display("FAIL starve_after got %b %h cnt %0d required 1 a0000020 0", if_rvalid, if_rdata, dut.starve_cnt);
    end
    step();
  endtask

  task automatic test_store_load;
    step();
    lsu_req = 1'b1; lsu_we = 1'b1; lsu_be = 4'b0011; lsu_addr = 32'h200; lsu_wdata = 32'hDEAD_BEEF;
    sample();
    n_run++; if (lsu_gnt !== 1'b1 || mem_we !== 1'b1 || mem_be !== 4'b0011 || mem_wdata !== 32'hDEAD_BEEF) begin
      n_fail++; $display("FAIL store_req got gnt %b we %b be %b wd %h required 1 1 0011 deadbeef", lsu_gnt, mem_we, mem_be, mem_wdata);
    end
    step();
    lsu_req = 1'b0; lsu_we = 1'b0; lsu_wdata = 32'd0;
    sample();
    n_run++; if (lsu_rvalid !== 1'b1 || lsu_rdata !== 32'd0) begin
      n_fail++; $display("FAIL store_ack got %b %h required 1 00000000", lsu_rvalid, lsu_rdata);
    end
    step();
    lsu_req = 1'b1; lsu_be = 4'hF;
    sample();
    n_run++; if (lsu_gnt !== 1'b1 || mem_we !== 1'b0) begin
      n_fail++; $display("FAIL load_req got gnt %b we %b required 1 0", lsu_gnt, mem_we);
    end
    step();
    lsu_req = 1'b0;
    sample();
    n_run++; if (lsu_rvalid !== 1'b1 || lsu_rdata !== 32'h0000_BEEF) begin
      n_fail++; $display("FAIL load_data got %b %h required 1 0000beef", lsu_rvalid, lsu_rdata);
    end
  endtask

  task automatic test_gnt_stall;
    step();
    mem_gnt = 1'b0; if_req = 1'b1; if_addr = 32'h30;
    sample();
    n_run++; if (mem_req !== 1'b1 || mem_addr !== 32'h30 || if_gnt !== 1'b0) begin
      n_fail++; $display("FAIL stall_if got req %b addr %h gnt %b required 1 30 0", mem_req, mem_addr, if_gnt);
    end
    step();
    lsu_req = 1'b1; lsu_we = 1'b0; lsu_be = 4'hF; lsu_addr = 32'h108;
    sample();
    n_run++; if (mem_addr !== 32'h108 || lsu_gnt !== 1'b0 || if_stall !== 1'b1) begin
      n_fail++; $display("FAIL stall_preempt got addr %h gnt %b stall %b required 108 0 1", mem_addr, lsu_gnt, if_stall);
    end
    step();
    mem_gnt = 1'b1;
    sample();
    n_run++; if (lsu_gnt !== 1'b1 || if_gnt !== 1'b0) begin
      n_fail++; $display("FAIL stall_release got lsu %b if %b required 1 0", lsu_gnt, if_gnt);
    end
    step();
    lsu_req = 1'b0;
    sample();
    n_run++; if (lsu_rdata !== 32'hA000_0108 || if_gnt !== 1'b1) begin
      n_fail++; $display("FAIL stall_lsu_rsp got %h if_gnt %b required a0000108 1", lsu_rdata, if_gnt);
    end
    step();
    if_req = 1'b0;
    sample();
    n_run++; if (if_rvalid !== 1'b1 || if_rdata !== 32'hA000_0030) begin
      n_fail++; $display("FAIL stall_if_rsp got %b %h required 1 a0000030", if_rvalid, if_rdata);
    end
  endtask

  task automatic test_reset_mid_txn;
    step();
    hold_resp = 1'b1;
    lsu_req = 1'b1; lsu_we = 1'b0; lsu_be = 4'hF; lsu_addr = 32'h104;
    sample();
    n_run++; if (lsu_gnt !== 1'b1) begin
      n_fail++; $display("FAIL rmid_gnt got %b required 1", lsu_gnt);
    end
    step();
    lsu_req = 1'b0;
    sample();
    n_run++; if (dut.owner_q !== OWN_LSU || lsu_rvalid !== 1'b0) begin
      n_fail++; $display("FAIL rmid_wait got owner %0d rvalid %b required 2 0", dut.owner_q, lsu_rvalid);
    end
    step();
    rst = 1'b1;
    sample();
    step();
    rst = 1'b0; hold_resp = 1'b0;
    inject_rv = 1'b1; inject_rd = 32'h5555_AAAA;
    sample();
    n_run++; if (lsu_rvalid !== 1'b0 || if_rvalid !== 1'b0 || lsu_rdata !== 32'd0) begin
      n_fail++; $display("FAIL rmid_straggler got lsu %b if %b data %h required 0 0 0", lsu_rvalid, if_rvalid, lsu_rdata);
    end
    step();
    inject_rv = 1'b0;
    sample();
    n_run++; if (dut.state_q !== ARB_IDLE) begin
      n_fail++; $display("FAIL rmid_state got %0d required 0", dut.state_q);
    end
    step();
    if_req = 1'b1; if_addr = 32'h0;
    sample();
    n_run++; if (if_gnt !== 1'b1) begin
      n_fail++; $display("FAIL rmid_regrant got %b required 1", if_gnt);
    end
    step();
    if_req = 1'b0;
    sample();
    n_run++; if (if_rvalid !== 1'b1 || if_rdata !== 32'hA000_0000) begin
      n_fail++; $display("FAIL rmid_if_rsp got %b %h required 1 a0000000", if_rvalid, if_rdata);
    end
  endtask

  initial begin
    rst = 1'b1; if_req = 1'b0; if_addr = '0;
    lsu_req = 1'b0; lsu_we = 1'b0; lsu_be = '0; lsu_addr = '0; lsu_wdata = '0;
    mem_gnt = 1'b1; hold_resp = 1'b0; inject_rv = 1'b0; inject_rd = '0;
    test_reset();
    test_both_same_cycle();
    test_if_back_to_back();
    test_starvation();
    test_store_load();
    test_gnt_stall();
    test_reset_mid_txn();
    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end

endmodule
